null_src_pkt_scheduler: RTL

- Sequences packet generation for the null source/sink block's source port.
- Issues one request per packet to the source datapath: lines-per-packet and sequence number.
- Waits for the source to report packet completion, then inserts a programmable idle gap.
- Stops after N packets, or runs continuously until stopped. Sits between the register file (start/stop/config) and the source packet generator.

---
 rtl/null_sched_pkg.sv | 13 +
 rtl/null_sched_gap_timer.sv | 17 +
 rtl/null_src_pkt_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/null_sched_pkg.sv
// null_sched_pkg: shared state, width constants and latched-config type for the null source scheduler
package null_sched_pkg;
  localparam int LPP_W = 16;
  localparam int SEQ_W = 16;
  localparam int CFG_CNT_W = 32;
  localparam int CFG_GAP_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, GAP} state_t;
  typedef struct packed {
    logic [CFG_CNT_W-1:0] num_pkts;
    logic [LPP_W-1:0]     lpp;
    logic [CFG_GAP_W-1:0] gap;
  } cfg_t;
endpackage

// File: rtl/null_sched_gap_timer.sv
// null_sched_gap_timer: loadable saturating down-counter with a zero flag
module null_sched_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/null_src_pkt_scheduler.sv
// null_src_pkt_scheduler: issues per-packet requests to the null source with idle gaps and stop control
// Optional watchdog on WAIT_DONE enabled by defining NULL_SCHED_TIMEOUT_EN.
module null_src_pkt_scheduler
  import null_sched_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int GAP_W = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             rfnoc_chdr_clk,
  input  logic             rfnoc_chdr_rst,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [CNT_W-1:0] cfg_num_pkts,
  input  logic [15:0]      cfg_lpp,
  input  logic [GAP_W-1:0] cfg_gap_cycles,
  output logic             pkt_req_valid,
  input  logic             pkt_req_ready,
  output logic [15:0]      pkt_req_lines,
  output logic [15:0]      pkt_req_seq,
  input  logic             pkt_done,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             done_pulse,
  output logic             err_timeout
);
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end
  state_t           r_state;
  cfg_t             r_cfg;
  logic             r_valid, r_busy, r_done, r_err, r_stop_pend;
  logic [SEQ_W-1:0] r_seq;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] w_num, w_sent_nxt;
  logic [GAP_W-1:0] w_gap;
  logic             w_last, w_stop, w_gap_zero, w_wd_zero;
  assign w_num      = CNT_W'(r_cfg.num_pkts);
  assign w_gap      = GAP_W'(r_cfg.gap);
  assign w_sent_nxt = r_sent + 1'b1;
  assign w_last     = (w_num != '0) && (w_sent_nxt == w_num);
  assign w_stop     = r_stop_pend | cfg_stop;
  // Loaded with gap-1 so the next valid lands exactly gap+1 cycles after pkt_done
  null_sched_gap_timer #(.W(GAP_W)) u_gap (
    .clk(rfnoc_chdr_clk), .rst(rfnoc_chdr_rst),
    .i_load(r_state == WAIT_DONE && pkt_done), .i_val(w_gap - 1'b1), .o_zero(w_gap_zero)
  );
`ifdef NULL_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  null_sched_gap_timer #(.W(WD_W)) u_wd (
    .clk(rfnoc_chdr_clk), .rst(rfnoc_chdr_rst),
    .i_load(r_state == REQ && pkt_req_ready), .i_val(WD_W'(TIMEOUT_CYC - 1)), .o_zero(w_wd_zero)
  );
`else
  assign w_wd_zero = 1'b0;
`endif
  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      r_state     <= IDLE;
      r_cfg       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_seq       <= '0;
      r_sent      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy      <= 1'b0;
          r_stop_pend <= 1'b0;
          if (cfg_start && !cfg_stop && !r_busy) begin
            r_cfg.num_pkts <= CFG_CNT_W'(cfg_num_pkts);
            r_cfg.lpp      <= (cfg_lpp == '0) ? LPP_W'(1) : cfg_lpp;
            r_cfg.gap      <= CFG_GAP_W'(cfg_gap_cycles);
            r_sent  <= '0;
            r_seq   <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (cfg_stop) r_stop_pend <= 1'b1;
          if (pkt_req_ready) begin
            r_valid <= 1'b0;
            r_seq   <= r_seq + 1'b1;
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (cfg_stop) r_stop_pend <= 1'b1;
          if (pkt_done) begin
            r_sent <= w_sent_nxt;
            if (w_stop || w_last) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else if (w_gap == '0) begin
              r_state <= REQ;
              r_valid <= 1'b1;
            end else r_state <= GAP;
          end else if (w_wd_zero) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        GAP: begin
          if (cfg_stop) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_gap_zero) begin
            r_state <= REQ;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign pkt_req_valid = r_valid;
  assign pkt_req_lines = r_cfg.lpp;
  assign pkt_req_seq   = r_seq;
  assign busy          = r_busy;
  assign sent_cnt      = r_sent;
  assign done_pulse    = r_done;
  assign err_timeout   = r_err;
endmodule
